// File: rtl/pulse_seq_pkg.sv
// pulse_seq_pkg: shared definitions for the pulse sequencer.
//   - state encoding (IDLE/HIGH/LOW/DONE) as localparams plus the FSM enum
//   - default counter width
//   - zero_to_one(): a configured length of 0 is run as 1
package pulse_seq_pkg;

  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_HIGH = HIGH,
    ST_LOW  = LOW,
    ST_DONE = DONE
  } state_t;

  function automatic int unsigned zero_to_one(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// phase_counter: CNT_W-bit loadable down-counter timing one HIGH or LOW phase.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-high reset, clears the count to 0
//   load   - load 'value' (takes priority over enable)
//   value  - phase length in cycles (>= 1)
//   enable - count down by one; holds at 1, never wraps
//   last   - high while the counter reads 1 (final cycle of the phase)
module phase_counter
  import pulse_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             enable,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (enable && (cnt > CNT_W'(1))) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: generates a burst of cfg_count pulses, each cfg_high cycles
// wide, separated by cfg_low-cycle gaps, under a start/busy/done handshake.
// Configuration is captured when a burst starts.
// Optional feature macro: PULSE_SEQ_REPEAT_EN adds cfg_repeat; when latched as
// 1 the burst loops forever (one gap, then pulse 0 again) with done strobing in
// the first gap cycle after each last pulse, until abort or reset.
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-high reset
//   start      - request a burst (sampled only in IDLE)
//   abort      - stop a running burst without a done strobe
//   cfg_high   - pulse width in cycles (0 runs as 1)
//   cfg_low    - gap width in cycles (0 runs as 1)
//   cfg_count  - pulses per burst (0 gives an immediate done)
//   cfg_repeat - (PULSE_SEQ_REPEAT_EN only) loop the burst
//   pulse      - registered pulse train
//   busy       - burst running
//   done       - one-cycle completion strobe
//   pulse_idx  - 0-based index of the current pulse, held after the burst
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  input  logic [CNT_W-1:0] cfg_count,
`ifdef PULSE_SEQ_REPEAT_EN
  input  logic             cfg_repeat,
`endif
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_idx
);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] h_len;
  logic [CNT_W-1:0] l_len;
  logic [CNT_W-1:0] n_len;
  logic             rep;
  logic [CNT_W-1:0] h_in;
  logic [CNT_W-1:0] l_in;
  logic             accept;
  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_last;
  logic             wrap;
  logic [CNT_W-1:0] idx_nxt;
  logic [CNT_W:0]   idx_p1;
  logic             last_pulse;

  assign h_in   = CNT_W'(zero_to_one(32'(cfg_high)));
  assign l_in   = CNT_W'(zero_to_one(32'(cfg_low)));
  assign accept = (state == ST_IDLE) && start && !abort;

  // One bit wider so a count of 2^CNT_W-1 compares without overflow.
  assign idx_p1     = {1'b0, pulse_idx} + (CNT_W+1)'(1);
  assign last_pulse = (idx_p1 >= {1'b0, n_len});

  phase_counter #(.CNT_W(CNT_W)) u_phase (
    .clk    (clk),
    .reset  (reset),
    .load   (cnt_load),
    .value  (cnt_val),
    .enable (cnt_en),
    .last   (cnt_last)
  );

  always_comb begin
    nxt      = state;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = h_len;
    wrap     = 1'b0;
    idx_nxt  = pulse_idx;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          idx_nxt = '0;
          if (cfg_count == '0) begin
            nxt = ST_DONE;
          end else begin
            nxt      = ST_HIGH;
            cnt_load = 1'b1;
            cnt_val  = h_in;
          end
        end
      end
      ST_HIGH: begin
        if (abort) begin
          nxt = ST_IDLE;
        end else if (cnt_last) begin
          if (!last_pulse || rep) begin
            nxt      = ST_LOW;
            cnt_load = 1'b1;
            cnt_val  = l_len;
            // A gap after the last pulse only exists when looping.
            wrap     = last_pulse;
          end else begin
            nxt = ST_DONE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_LOW: begin
        if (abort) begin
          nxt = ST_IDLE;
        end else if (cnt_last) begin
          nxt      = ST_HIGH;
          cnt_load = 1'b1;
          cnt_val  = h_len;
          idx_nxt  = last_pulse ? '0 : (pulse_idx + CNT_W'(1));
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pulse     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_idx <= '0;
      h_len     <= '0;
      l_len     <= '0;
      n_len     <= '0;
`ifdef PULSE_SEQ_REPEAT_EN
      rep       <= 1'b0;
`endif
    end else begin
      state     <= nxt;
      pulse     <= (nxt == ST_HIGH);
      busy      <= (nxt == ST_HIGH) || (nxt == ST_LOW);
      done      <= (nxt == ST_DONE) || wrap;
      pulse_idx <= idx_nxt;
      if (accept) begin
        h_len <= h_in;
        l_len <= l_in;
        n_len <= cfg_count;
`ifdef PULSE_SEQ_REPEAT_EN
        rep   <= cfg_repeat;
`endif
      end
    end
  end

`ifndef PULSE_SEQ_REPEAT_EN
  assign rep = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_sequencer.sv
module tb_pulse_sequencer;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_low;
  logic [CNT_W-1:0] cfg_count;
  logic             cfg_repeat;
  logic             pulse;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulse_idx;

  int n_cmp = 0;
  int n_bad = 0;
  int hold_idx = 0;

  pulse_sequencer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .cfg_high  (cfg_high),
    .cfg_low   (cfg_low),
    .cfg_count (cfg_count),
`ifdef PULSE_SEQ_REPEAT_EN
    .cfg_repeat(cfg_repeat),
`endif
    .pulse     (pulse),
    .busy      (busy),
    .done      (done),
    .pulse_idx (pulse_idx)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic p, input logic b, input logic d, input int idx);
    logic [CNT_W-1:0] i8;
    i8 = CNT_W'(idx);
    return 32'({p, b, d, i8});
  endfunction

  function automatic logic [31:0] observed();
    return 32'({pulse, busy, done, pulse_idx});
  endfunction

  // Expected outputs for interval t (between edges E_t and E_t+1 after the
  // start edge E0), from the burst timing rules: pulse p occupies
  // [p*(h+l), p*(h+l)+h), gaps fill the rest, done follows the active span.
  function automatic logic [31:0] model_at(input int t, input int h, input int l,
                                           input int n, input int ab);
    int active;
    int per;
    int last_idx;
    active   = (n == 0) ? 0 : n * h + (n - 1) * l;
    per      = h + l;
    last_idx = (n == 0) ? 0 : n - 1;
    if (ab >= 0 && ab < active && t > ab)
      return pack(1'b0, 1'b0, 1'b0, ab / per);
    if (t < active)
      return pack((t % per) < h, 1'b1, 1'b0, t / per);
    if (t == active)
      return pack(1'b0, 1'b0, 1'b1, last_idx);
    return pack(1'b0, 1'b0, 1'b0, last_idx);
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge.
  // mode_start: 0 none, 1 random start pulses while busy, 2 start held while busy.
  task automatic run_burst(input int h_raw, input int l_raw, input int n,
                           input int ab, input int mode_start, input string name);
    int h, l, active, end_t;
    h      = (h_raw == 0) ? 1 : h_raw;
    l      = (l_raw == 0) ? 1 : l_raw;
    active = (n == 0) ? 0 : n * h + (n - 1) * l;
    end_t  = (ab >= 0 && ab < active) ? ab + 1 : active + 1;
    cfg_high   = CNT_W'(h_raw);
    cfg_low    = CNT_W'(l_raw);
    cfg_count  = CNT_W'(n);
    cfg_repeat = 1'b0;
    start      = 1'b1;
    abort      = 1'b0;
    @(posedge clk);
    #1;
    start     = 1'b0;
    cfg_high  = CNT_W'($urandom);
    cfg_low   = CNT_W'($urandom);
    cfg_count = CNT_W'($urandom);
    for (int t = 0; t <= end_t; t++) begin
      if (t <= active && (ab < 0 || t <= ab))
        start = (mode_start == 2) ? 1'b1 : (mode_start == 1) ? 1'($urandom % 2) : 1'b0;
      else
        start = 1'b0;
      abort = (t == ab);
      @(negedge clk);
      check_val($sformatf("%s t%0d", name, t), observed(), model_at(t, h, l, n, ab));
      if (t < end_t) begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    hold_idx = int'(model_at(end_t, h, l, n, ab) & 32'hFF);
  endtask

  initial begin
    int h, l, n, ab, act, ms;
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    cfg_high   = '0;
    cfg_low    = '0;
    cfg_count  = '0;
    cfg_repeat = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_state", observed(), pack(1'b0, 1'b0, 1'b0, 0));
    reset = 1'b0;
    @(negedge clk);
    check_val("idle_after_reset", observed(), pack(1'b0, 1'b0, 1'b0, 0));

    run_burst(2, 3, 3, -1, 0, "basic");
    run_burst(0, 0, 2, -1, 0, "zero_hl");
    run_burst(5, 2, 0, -1, 0, "zero_count");
    run_burst(4, 4, 5, 13, 0, "abort_low2");
    run_burst(3, 1, 2, -1, 0, "restart_after_abort");
    run_burst(3, 2, 4, -1, 2, "start_while_busy");
    run_burst(2, 2, 2, 6, 0, "abort_in_done");

    // start and abort together in IDLE: nothing starts
    cfg_high  = 8'd3;
    cfg_low   = 8'd3;
    cfg_count = 8'd2;
    start     = 1'b1;
    abort     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val($sformatf("start_abort_idle %0d", k), observed(), pack(1'b0, 1'b0, 1'b0, hold_idx));
    end

    // asynchronous reset in the middle of a HIGH phase
    cfg_high  = 8'd5;
    cfg_low   = 8'd2;
    cfg_count = 8'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check_val("pre_reset_high", observed(), pack(1'b1, 1'b1, 1'b0, 0));
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_val("async_reset_pulse", 32'(pulse), 32'd0);
    check_val("async_reset_busy", 32'(busy), 32'd0);
    check_val("async_reset_all", observed(), pack(1'b0, 1'b0, 1'b0, 0));
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_val("idle_after_async_reset", observed(), pack(1'b0, 1'b0, 1'b0, 0));
    end

    // randomized bursts against the model
    for (int it = 0; it < 30; it++) begin
      h   = $urandom_range(0, 6);
      l   = $urandom_range(0, 6);
      n   = $urandom_range(0, 5);
      act = (n == 0) ? 0 : n * ((h == 0) ? 1 : h) + (n - 1) * ((l == 0) ? 1 : l);
      ab  = ($urandom % 3 == 0) ? $urandom_range(0, act) : -1;
      ms  = $urandom_range(0, 2);
      run_burst(h, l, n, ab, ms, $sformatf("rand%0d", it));
    end

    // maximum settings
    run_burst(255, 255, 2, -1, 0, "max_hl");
    run_burst(1, 1, 255, -1, 0, "max_count");

`ifdef PULSE_SEQ_REPEAT_EN
    // repeat mode: H=1, L=1, count=2 loops 1,0,1,0 with done on every 4th cycle
    cfg_high   = 8'd1;
    cfg_low    = 8'd1;
    cfg_count  = 8'd2;
    cfg_repeat = 1'b1;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    cfg_repeat = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      check_val($sformatf("repeat t%0d", t), observed(),
                pack((t % 2) == 0, 1'b1, (t % 4) == 3, (t % 4) / 2));
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check_val("repeat_abort", observed(), pack(1'b0, 1'b0, 1'b0, 0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
